// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction-memory read arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_arb_pkg;

    // Arbiter transaction state: waiting for a request, or one read outstanding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // Requester port numbers, also used as bit positions in req_valid/resp_valid.
    localparam int PORT_FETCH = 0;
    localparam int PORT_LOAD  = 1;

    // Identifies which requester owns the outstanding read.
    typedef logic grant_id_t;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the read arbiter.
// Latency: n/a (wiring only).
// Backpressure: none here; requesters hold req_valid until their resp_valid pulse.
interface mem_read_arbiter_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    // Requester side: bit0 = fetch, bit1 = load.
    logic [1:0]            req_valid;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [1:0]            resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;
    logic                  busy;

    // Memory read port.
    logic [ADDR_WIDTH-1:0] S_R_ADDR;
    logic                  S_R_ADDR_VALID;
    logic [DATA_WIDTH-1:0] S_R_DATA;
    logic                  S_R_DATA_VALID;

    // Arbiter view.
    modport slave (
        input  req_valid, req_addr0, req_addr1, S_R_DATA, S_R_DATA_VALID,
        output resp_valid, resp_data, resp_err, busy, S_R_ADDR, S_R_ADDR_VALID
    );

    // Requester / memory environment view.
    modport master (
        output req_valid, req_addr0, req_addr1, S_R_DATA, S_R_DATA_VALID,
        input  resp_valid, resp_data, resp_err, busy, S_R_ADDR, S_R_ADDR_VALID
    );

endinterface

// File: rtl/mem_arb_prio_sel.sv
// Fixed-priority winner select (load over fetch) with fetch starvation guard.
// Latency: purely combinational; result is registered by the arbiter at the grant.
// Backpressure: none; only evaluated when the arbiter is idle.
module mem_arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic [1:0]       req_valid,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             any_req,
    output grant_id_t        winner,
    output logic [CNT_W-1:0] starve_cnt_nxt
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic fetch_starved;

    // Pick the winner and the starve count that goes with it if this becomes a grant.
    always_comb begin
        any_req        = |req_valid;
        fetch_starved  = req_valid[PORT_FETCH] && (starve_cnt == LIMIT);
        winner         = grant_id_t'(PORT_FETCH);
        starve_cnt_nxt = '0;
        if (req_valid[PORT_LOAD] && !fetch_starved) begin
            winner = grant_id_t'(PORT_LOAD);
        end
        // Only a load win over a waiting fetch counts; anything else resets the run.
        if ((winner == grant_id_t'(PORT_LOAD)) && req_valid[PORT_FETCH]) begin
            starve_cnt_nxt = (starve_cnt == LIMIT) ? LIMIT : starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one instruction-memory read port between fetch (port 0) and load (port 1); one read in flight.
// Latency: grant registered 1 edge after req_valid; resp_valid pulses 1 edge after S_R_DATA_VALID; 1 idle cycle between reads.
// Backpressure: requesters hold req_valid until resp_valid; optional ARB_TIMEOUT_EN bounds the wait for S_R_DATA_VALID.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic              clk,
    input logic              reset,
    mem_read_arbiter_if.slave bus
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    // The optional wait counter is 16 bits wide, so the limit must fit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..65535");
    end

    arb_state_t            state_q, state_nxt;
    grant_id_t             grant_q, grant_nxt;
    logic [CNT_W-1:0]      starve_q, starve_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic                  addr_vld_q, addr_vld_nxt;
    logic                  busy_q, busy_nxt;
    logic [1:0]            resp_vld_q, resp_vld_nxt;
    logic [DATA_WIDTH-1:0] resp_dat_q, resp_dat_nxt;

    logic                  any_req;
    grant_id_t             winner;
    logic [CNT_W-1:0]      sel_starve_nxt;
    logic [1:0]            grant_vec;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]           wait_q, wait_nxt;
    logic                  resp_err_q, resp_err_nxt;
`endif

    mem_arb_prio_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_prio_sel (
        .req_valid      (bus.req_valid),
        .starve_cnt     (starve_q),
        .any_req        (any_req),
        .winner         (winner),
        .starve_cnt_nxt (sel_starve_nxt)
    );

    assign grant_vec = (grant_q == grant_id_t'(PORT_LOAD)) ? 2'b10 : 2'b01;

    // State register; reset abandons any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt    = state_q;
        grant_nxt    = grant_q;
        starve_nxt   = starve_q;
        addr_nxt     = addr_q;
        addr_vld_nxt = addr_vld_q;
        busy_nxt     = busy_q;
        resp_vld_nxt = 2'b00;
        resp_dat_nxt = resp_dat_q;
`ifdef ARB_TIMEOUT_EN
        wait_nxt     = wait_q;
        resp_err_nxt = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Data arriving with nothing outstanding is stale and dropped.
                if (any_req) begin
                    state_nxt    = ST_BUSY;
                    grant_nxt    = winner;
                    starve_nxt   = sel_starve_nxt;
                    addr_nxt     = (winner == grant_id_t'(PORT_LOAD)) ? bus.req_addr1 : bus.req_addr0;
                    addr_vld_nxt = 1'b1;
                    busy_nxt     = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wait_nxt     = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (bus.S_R_DATA_VALID) begin
                    state_nxt    = ST_IDLE;
                    resp_vld_nxt = grant_vec;
                    resp_dat_nxt = bus.S_R_DATA;
                    addr_vld_nxt = 1'b0;
                    busy_nxt     = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (wait_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // Last allowed BUSY cycle with no data: return an error response.
                    state_nxt    = ST_IDLE;
                    resp_vld_nxt = grant_vec;
                    resp_dat_nxt = '0;
                    resp_err_nxt = 1'b1;
                    addr_vld_nxt = 1'b0;
                    busy_nxt     = 1'b0;
                end else begin
                    wait_nxt     = wait_q + 16'd1;
`endif
                end
            end
        endcase
    end

    // Output and bookkeeping registers, all cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q    <= grant_id_t'(PORT_FETCH);
            starve_q   <= '0;
            addr_q     <= '0;
            addr_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            resp_vld_q <= 2'b00;
            resp_dat_q <= '0;
        end else begin
            grant_q    <= grant_nxt;
            starve_q   <= starve_nxt;
            addr_q     <= addr_nxt;
            addr_vld_q <= addr_vld_nxt;
            busy_q     <= busy_nxt;
            resp_vld_q <= resp_vld_nxt;
            resp_dat_q <= resp_dat_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Wait counter and error flag for the bounded memory wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wait_q     <= wait_nxt;
            resp_err_q <= resp_err_nxt;
        end
    end

    assign bus.resp_err = resp_err_q;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign bus.resp_valid     = resp_vld_q;
    assign bus.resp_data      = resp_dat_q;
    assign bus.busy           = busy_q;
    assign bus.S_R_ADDR       = addr_q;
    assign bus.S_R_ADDR_VALID = addr_vld_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Testbench for mem_read_arbiter: scoreboard of expected responses checked on every resp_valid pulse.
// Latency: memory model answers a configurable number of cycles after S_R_ADDR_VALID.
// Backpressure: requesters hold req_valid until their response, as the arbiter expects.
`timescale 1ns/1ps
module tb_mem_read_arbiter;

    localparam int AW = 64;
    localparam int DW = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_read_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .STARVE_LIMIT   (SL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [1:0]    port;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          exp_q[$];
    int            n_checks  = 0;
    int            n_fail    = 0;
    logic [AW-1:0] seen_addr = '0;
    logic [DW-1:0] last_data = '0;

    // Count one comparison and report it if it mismatches.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic push_exp(input logic [1:0] port, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.port = port;
        e.addr = addr;
        e.data = data;
        e.err  = err;
        exp_q.push_back(e);
    endtask

    // Memory model: wait for a read request, answer dly cycles later with dat.
    task automatic serve(input int dly, input logic [DW-1:0] dat);
        int n = 0;
        while (!bus.S_R_ADDR_VALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.S_R_ADDR_VALID) begin
            chk("serve_no_request", 64'(bus.S_R_ADDR_VALID), 64'd1);
            return;
        end
        repeat (dly - 1) @(negedge clk);
        bus.S_R_DATA       = dat;
        bus.S_R_DATA_VALID = 1'b1;
        @(negedge clk);
        bus.S_R_DATA_VALID = 1'b0;
    endtask

    task automatic stray_data(input logic [DW-1:0] dat);
        bus.S_R_DATA       = dat;
        bus.S_R_DATA_VALID = 1'b1;
        @(negedge clk);
        bus.S_R_DATA_VALID = 1'b0;
    endtask

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.S_R_ADDR_VALID) seen_addr = bus.S_R_ADDR;
            if (bus.resp_valid != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_port", 64'(bus.resp_valid), 64'(e.port));
                    chk("resp_data", 64'(bus.resp_data), 64'(e.data));
                    chk("resp_err", 64'(bus.resp_err), 64'(e.err));
                    chk("grant_addr", 64'(seen_addr), 64'(e.addr));
                    chk("busy_after_resp", 64'(bus.busy), 64'd0);
                    chk("addr_vld_after_resp", 64'(bus.S_R_ADDR_VALID), 64'd0);
                    last_data = e.data;
                end
            end
        end
    end

    initial begin
        bus.req_valid      = 2'b00;
        bus.req_addr0      = '0;
        bus.req_addr1      = '0;
        bus.S_R_DATA       = '0;
        bus.S_R_DATA_VALID = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_resp_data", 64'(bus.resp_data), 64'd0);
        chk("rst_resp_err", 64'(bus.resp_err), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_addr", 64'(bus.S_R_ADDR), 64'd0);
        chk("rst_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Single fetch, memory answers 3 cycles after the request.
        push_exp(2'b01, 64'h1000, 32'h0000_0013, 1'b0);
        bus.req_addr0 = 64'h1000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("t1_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd1);
        chk("t1_busy", 64'(bus.busy), 64'd1);
        chk("t1_addr", 64'(bus.S_R_ADDR), 64'h1000);
        serve(3, 32'h0000_0013);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);
        chk("t1_idle_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);

        // Both ports requesting continuously: four loads, then fetch, then load.
        bus.req_addr0 = 64'h2000;
        bus.req_addr1 = 64'h8000;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) push_exp(2'b01, 64'h2000, 32'hD000_0000 + 32'(i), 1'b0);
            else        push_exp(2'b10, 64'h8000, 32'hD000_0000 + 32'(i), 1'b0);
        end
        bus.req_valid = 2'b11;
        for (int i = 0; i < 6; i++) serve(1, 32'hD000_0000 + 32'(i));
        bus.req_valid = 2'b00;

        // Data while idle is ignored and resp_data holds its last value.
        repeat (2) @(negedge clk);
        stray_data(32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        chk("idle_pulse_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("idle_pulse_busy", 64'(bus.busy), 64'd0);
        chk("idle_pulse_data_hold", 64'(bus.resp_data), 64'(last_data));

        // Reset during BUSY abandons the read; late data is ignored.
        bus.req_addr1 = 64'h3000;
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("t4_granted", 64'(bus.S_R_ADDR_VALID), 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("t4_rst_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);
        chk("t4_rst_addr", 64'(bus.S_R_ADDR), 64'd0);
        chk("t4_rst_busy", 64'(bus.busy), 64'd0);
        chk("t4_rst_resp_data", 64'(bus.resp_data), 64'd0);
        bus.req_valid = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        stray_data(32'h3333_3333);
        repeat (2) @(negedge clk);
        chk("t4_late_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);
        push_exp(2'b01, 64'h4000, 32'h4444_0001, 1'b0);
        bus.req_addr0 = 64'h4000;
        bus.req_valid = 2'b01;
        @(negedge clk);
        serve(2, 32'h4444_0001);
        bus.req_valid = 2'b00;

        // Load drops its request after one cycle; the response still arrives.
        repeat (2) @(negedge clk);
        push_exp(2'b10, 64'h5000, 32'h5555_0005, 1'b0);
        bus.req_addr1 = 64'h5000;
        bus.req_valid = 2'b10;
        @(negedge clk);
        @(negedge clk);
        bus.req_valid = 2'b00;
        serve(3, 32'h5555_0005);
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", 64'(bus.busy), 64'd0);

`ifdef ARB_TIMEOUT_EN
        // Memory never answers: error response after TO busy cycles.
        begin
            int busy_cycles = 0;
            int n = 0;
            push_exp(2'b01, 64'h6000, 32'h0, 1'b1);
            bus.req_addr0 = 64'h6000;
            bus.req_valid = 2'b01;
            @(negedge clk);
            while (bus.resp_valid == 2'b00 && n < 40) begin
                if (bus.busy) busy_cycles++;
                n++;
                @(negedge clk);
            end
            chk("to_resp_seen", 64'(bus.resp_valid != 2'b00), 64'd1);
            chk("to_busy_cycles", 64'(busy_cycles), 64'(TO));
            bus.req_valid = 2'b00;
            @(negedge clk);
            stray_data(32'h6666_6666);
            repeat (3) @(negedge clk);
            chk("to_late_addr_vld", 64'(bus.S_R_ADDR_VALID), 64'd0);
        end
`endif

        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
Name: mem_read_arbiter

Overview:
- Shares the single instruction-memory read port (S_R_ADDR / S_R_DATA handshake) between two requesters: port 0 = fetch stage, port 1 = load unit.
- Exactly one transaction outstanding at a time.
- Load port has fixed priority, with a starvation limit that guarantees fetch forward progress.
- Sits between the pipeline front end / memory stage and the memory read interface.

Parameters:
- ADDR_WIDTH, 64, address width of requests and S_R_ADDR.
- DATA_WIDTH, 32, read data width (S_R_DATA, resp data).
- STARVE_LIMIT, 4, maximum consecutive load grants while fetch is waiting.
- TIMEOUT_CYCLES, 256, maximum wait for S_R_DATA_VALID (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  2  per-port request; bit0 = fetch, bit1 = load
- req_addr0  in  ADDR_WIDTH  fetch address
- req_addr1  in  ADDR_WIDTH  load address
- resp_valid  out  2  one-cycle response pulse per port
- resp_data  out  DATA_WIDTH  response data, shared by both ports, qualified by resp_valid
- resp_err  out  1  response is a timeout error, qualified by resp_valid
- busy  out  1  transaction outstanding
- S_R_ADDR  out  ADDR_WIDTH  memory read address
- S_R_ADDR_VALID  out  1  memory read request
- S_R_DATA  in  DATA_WIDTH  memory read data
- S_R_DATA_VALID  in  1  memory data valid

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; grant_id=0; starve_cnt=0. Reset mid-transaction abandons it: no response is issued, and a later S_R_DATA_VALID in IDLE is ignored.
- All outputs are registered.
- FSM IDLE:
  - If any req_valid bit is set, choose a winner (arbitration below), latch winner id and address into S_R_ADDR, set S_R_ADDR_VALID=1 and busy=1, go to BUSY.
  - S_R_DATA_VALID in IDLE is ignored.
- FSM BUSY:
  - Hold S_R_ADDR and S_R_ADDR_VALID stable.
  - On S_R_DATA_VALID: latch S_R_DATA into resp_data, pulse resp_valid[grant_id] for exactly one cycle, clear S_R_ADDR_VALID and busy, go to IDLE.
- Latency:
  - req_valid sampled at edge N gives S_R_ADDR_VALID=1 after edge N.
  - S_R_DATA_VALID sampled at edge M gives the resp_valid pulse after edge M.
  - The next grant is decided at edge M+1, so there is one idle cycle between transactions.
- Requester rules:
  - Hold req_valid and address until own resp_valid.
  - Dropping req_valid while granted does not cancel; the response is still delivered.
  - A request pending on the cycle of its own resp_valid is treated as a new request.
- Arbitration:
  - Only one request set: that port wins.
  - Both set: load (port 1) wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
- starve_cnt:
  - +1 when load wins while req_valid[0]=1.
  - Cleared when fetch wins or req_valid[0]=0 at the grant.
  - Saturates at STARVE_LIMIT; width $clog2(STARVE_LIMIT+1).
- resp_data holds its last value between responses.
- resp_valid is never set on both bits at once.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - 16-bit wait counter, cleared on entering BUSY, +1 each BUSY cycle.
  - When the counter reaches TIMEOUT_CYCLES without S_R_DATA_VALID: pulse resp_valid[grant_id] with resp_err=1 and resp_data=0, clear S_R_ADDR_VALID, go to IDLE.
  - S_R_DATA_VALID on the same cycle as the timeout wins (normal response, resp_err=0).
- Undefined: no counter; resp_err tied to 0; BUSY waits indefinitely.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum for IDLE/BUSY states.
  - localparams PORT_FETCH=0 and PORT_LOAD=1.
  - typedef for grant id.
- One sub-module: mem_arb_prio_sel. Combinational winner select plus starve-counter next-value logic.

Test Plan:
- Reset, then req_valid=01, addr0=0x1000; S_R_DATA_VALID 3 cycles after S_R_ADDR_VALID with data 0x00000013 -> S_R_ADDR=0x1000; resp_valid=01, resp_data=0x13 one cycle after the data; busy falls.
- req_valid=11 held continuously, memory responds in 1 cycle, STARVE_LIMIT=4 -> grant order load, load, load, load, fetch, load...
- S_R_DATA_VALID pulsed while IDLE with no request -> no resp_valid; S_R_ADDR_VALID stays 0.
- Reset asserted low during BUSY, then data returns after release -> outputs 0 immediately; no resp_valid; next request served normally.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never responds -> after 8 BUSY cycles resp_valid pulses for the granted port with resp_err=1 and resp_data=0; late data is ignored.
- Granted load drops req_valid after 1 cycle -> its response is still delivered on resp_valid[1] when the data arrives.
